act_packer: RTL and testbench
=============================

ACT_PACKER -- requirements
Module: act_packer

Interface
REQ-001 Parameter O_CH, default 64: number of output channels drained per row.
REQ-002 Parameter OUT_ROW_LENGTH, default 4: sign bits per channel, i.e. width of sum_in.
REQ-003 Parameter WORD_W, default 16: output word width; O_CH*OUT_ROW_LENGTH SHALL be a multiple of WORD_W.
REQ-004 Parameter FIFO_DEPTH, default 16: words held; SHALL be >= O_CH*OUT_ROW_LENGTH/WORD_W.
REQ-005 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_in  input  1  synchronous, active-high reset.
REQ-007 start_in  input  1  one-cycle request to drain one row from the PE array.
REQ-008 pop_out  output  1  drives the PE array's pop_in.
REQ-009 sum_in  input  OUT_ROW_LENGTH  sign bits from the PE array's sum_out, channel = pop index in the same cycle.
REQ-010 out_data  output  WORD_W  head-of-FIFO packed word.
REQ-011 out_valid  output  1  out_data holds a valid word.
REQ-012 out_ready  input  1  consumer accepts word when out_valid && out_ready.
REQ-013 busy_out  output  1  high while not IDLE.
REQ-014 done_out  output  1  one-cycle pulse after the last channel is captured.

Function
REQ-015 FSM states: IDLE, POP, DONE; IDLE->POP on start_in && FIFO empty; POP->DONE after O_CH POP cycles; DONE->IDLE unconditionally.
REQ-016 start_in in any other state, or in IDLE with FIFO non-empty, SHALL be ignored (not queued).
REQ-017 pop_out SHALL be 1 in exactly the O_CH consecutive POP cycles and 0 otherwise; pop_out is never interrupted, as the PE array restarts its pop index whenever pop_in drops.
REQ-018 In POP cycle c (c = 0..O_CH-1), sum_in SHALL be captured as channel c, with no added latency.
REQ-019 Packing: channels 4k..4k+3 form word k; channel 4k occupies out_data[15:12], 4k+3 occupies [3:0]; sum_in bit order is preserved (generalised: WORD_W/OUT_ROW_LENGTH channels per word, lowest channel in MSBs).
REQ-020 Word k SHALL be pushed at the clock edge ending POP cycle 4k+3; out_valid for it rises in the following cycle at the earliest (first-word fall-through, registered storage).
REQ-021 FIFO SHALL be circular with read/write pointers wrapping at FIFO_DEPTH and an occupancy counter 0..FIFO_DEPTH.
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged and keep word order.
REQ-023 out_data SHALL remain stable while out_valid && !out_ready.
REQ-024 busy_out = (state != IDLE); done_out = (state == DONE).
REQ-025 A push when full cannot occur by construction; no overflow handling is required, but the bench SHALL assert it never happens.

Reset
REQ-026 rst_in high at a clock edge SHALL force state IDLE, pop_count 0, FIFO pointers and occupancy 0, and the packing shift register 0.
REQ-027 After reset: pop_out=0, out_valid=0, busy_out=0, done_out=0, out_data=0.
REQ-028 Reset during POP SHALL abort the row, discard any partial word and all FIFO contents, and drop pop_out in the next cycle.

Configuration
REQ-029 Macro ACT_PACKER_PARITY_EN: when defined, add output out_parity (1 bit) = XOR-reduction of out_data, valid with out_valid, 0 on reset; when undefined the port and its logic are absent and behaviour is otherwise identical.

Verification
REQ-030 Reset then start_in pulse with sum_in = c[3:0] in POP cycle c, out_ready=1 -> 64 pop_out cycles; 16 words 16'h0123, 16'h4567, ..., 16'hCDEF repeating; done_out pulses once at cycle 65 after start.
REQ-031 out_ready=0 throughout a row -> FIFO reaches 16 words with no loss; a second start_in is ignored (pop_out stays 0); after out_ready=1, 16 words drain in order.
REQ-032 Reset asserted at POP cycle 30 -> pop_out=0, out_valid=0 next cycle; a new start_in yields a full, correct row.
REQ-033 out_ready toggling 1,0,1,0 during POP -> simultaneous push/pop cycles; word sequence identical to REQ-030 and no FIFO overflow.
REQ-034 With ACT_PACKER_PARITY_EN, word 16'h0123 -> out_parity=0; word 16'h4567 -> out_parity=0; word 16'h0001 -> out_parity=1.

Source files
------------

// File: rtl/act_packer.sv
// rtl/act_packer.sv - drains one PE-array row of sign bits, packs them into words and queues them in a FIFO
//
// Ports:
//   clk_in      single clock, rising edge
//   rst_in      synchronous active-high reset
//   start_in    one-cycle request to drain a row (honoured only when idle with an empty FIFO)
//   pop_out     drives the PE array pop_in; high for exactly O_CH consecutive cycles per row
//   sum_in      OUT_ROW_LENGTH sign bits of the channel being popped this cycle
//   out_data    head-of-FIFO packed word (0 while empty)
//   out_valid   out_data holds a valid word
//   out_ready   consumer accepts the head word when out_valid && out_ready
//   busy_out    high while the FSM is not idle
//   done_out    one-cycle pulse after the last channel has been captured
//   out_parity  XOR of out_data (only when ACT_PACKER_PARITY_EN is defined)
//
// Optional feature macro: ACT_PACKER_PARITY_EN

module act_packer #(
    parameter int O_CH           = 64,
    parameter int OUT_ROW_LENGTH = 4,
    parameter int WORD_W         = 16,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      start_in,
    output logic                      pop_out,
    input  logic [OUT_ROW_LENGTH-1:0] sum_in,
    output logic [WORD_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy_out,
`ifdef ACT_PACKER_PARITY_EN
    output logic                      out_parity,
`endif
    output logic                      done_out
);

    localparam int CPW = WORD_W / OUT_ROW_LENGTH;
    localparam int NW  = (O_CH > 1) ? $clog2(O_CH) : 1;
    localparam int SW  = (CPW > 1) ? $clog2(CPW) : 1;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [NW-1:0]       r_pop_count;
    logic [SW-1:0]       r_slot;
    logic [WORD_W-1:0]   r_shift;

    logic [WORD_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic [WORD_W-1:0]   w_word;
    logic                w_push;
    logic                w_pop;
    logic                w_empty;

    // Completed word = the channels already shifted in plus this cycle's
    // sum_in in the LSBs, so the lowest channel lands in the MSBs.
    generate
        if (CPW > 1) begin : g_multi
            assign w_word = {r_shift[WORD_W-OUT_ROW_LENGTH-1:0], sum_in};
        end else begin : g_single
            assign w_word = sum_in;
        end
    endgenerate

    assign w_empty   = (r_count == '0);
    assign w_push    = (r_state == S_POP) && (r_slot == SW'(CPW - 1));
    assign w_pop     = out_valid && out_ready;

    assign pop_out   = (r_state == S_POP);
    assign busy_out  = (r_state != S_IDLE);
    assign done_out  = (r_state == S_DONE);
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];

`ifdef ACT_PACKER_PARITY_EN
    assign out_parity = ^out_data;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_pop_count <= '0;
            r_slot      <= '0;
            r_shift     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Requests while the FIFO still holds words are dropped,
                    // which guarantees a whole row always fits.
                    if (start_in && w_empty) begin
                        r_state     <= S_POP;
                        r_pop_count <= '0;
                        r_slot      <= '0;
                    end
                end
                S_POP: begin
                    r_shift <= w_word;
                    r_slot  <= (r_slot == SW'(CPW - 1)) ? '0 : r_slot + 1'b1;
                    if (r_pop_count == NW'(O_CH - 1)) begin
                        r_state     <= S_DONE;
                        r_pop_count <= '0;
                    end else begin
                        r_pop_count <= r_pop_count + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage array is not reset; occupancy gates everything read from it.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_act_packer.sv
// tb/tb_act_packer.sv - scoreboard bench for act_packer with a channel-list reference model

module tb_act_packer;

    localparam int O_CH  = 64;
    localparam int ORL   = 4;
    localparam int WW    = 16;
    localparam int DEPTH = 16;
    localparam int CPW   = WW / ORL;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b1;
    logic            start_in = 1'b0;
    logic            pop_out;
    logic [ORL-1:0]  sum_in = '0;
    logic [WW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            busy_out;
    logic            done_out;
`ifdef ACT_PACKER_PARITY_EN
    logic            out_parity;
`endif

    act_packer #(.O_CH(O_CH), .OUT_ROW_LENGTH(ORL), .WORD_W(WW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .start_in  (start_in),
        .pop_out   (pop_out),
        .sum_in    (sum_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy_out  (busy_out),
`ifdef ACT_PACKER_PARITY_EN
        .out_parity(out_parity),
`endif
        .done_out  (done_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    logic [WW-1:0] exp_q[$];
    logic [ORL-1:0] chans[$];   // channel values of the row in progress
    int  ch_idx      = 0;
    bit  pattern_mode = 1'b0;
    int  ready_mode   = 0;      // 0: always 1, 1: always 0, 2: toggle, 3: random

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one cycle; then drive the channel for this cycle if popping.
    task automatic tick();
        logic [ORL-1:0] v;
        logic [WW-1:0]  w;
        @(posedge clk_in);
        #1;
        if (pop_out) begin
            v = pattern_mode ? ORL'(ch_idx) : ORL'($urandom);
            sum_in = v;
            chans.push_back(v);
            ch_idx++;
            if (chans.size() == CPW) begin
                w = '0;
                for (int i = 0; i < CPW; i++) w = (w << ORL) | WW'(chans[i]);
                exp_q.push_back(w);
                chans.delete();
            end
        end else begin
            ch_idx = 0;
            chans.delete();
            sum_in = ORL'($urandom);
        end
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            2: out_ready = ~out_ready;
            default: out_ready = 1'($urandom);
        endcase
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while ((out_valid || busy_out || exp_q.size() != 0) && n < 600) begin
            tick();
            n++;
        end
        check({name, "_drain_timeout"}, int'(n >= 600), 0);
    endtask

    task automatic run_row(input string name, input bit pat);
        int first_pop = -1, last_pop = -1, pops = 0, done_at = -1, dones = 0;
        pattern_mode = pat;
        wait_empty({name, "_pre"});
        start_in = 1'b1;
        for (int k = 1; k <= 72; k++) begin
            tick();
            if (k == 1) start_in = 1'b0;
            if (pop_out) begin
                if (first_pop < 0) first_pop = k;
                last_pop = k;
                pops++;
            end
            if (done_out) begin
                dones++;
                done_at = k;
            end
        end
        check({name, "_first_pop"}, first_pop, 1);
        check({name, "_pop_cycles"}, pops, O_CH);
        check({name, "_last_pop"}, last_pop, O_CH);
        check({name, "_done_cycle"}, done_at, O_CH + 1);
        check({name, "_done_pulses"}, dones, 1);
    endtask

    // Monitor: pop the scoreboard on every accepted word.
    logic [WW-1:0] hold_data;
    bit            hold_valid = 1'b0;

    always @(negedge clk_in) begin
        logic [WW-1:0] e;
        if (!rst_in) begin
            if (hold_valid && out_valid) begin
                total++;
                if (out_data !== hold_data) begin
                    bad++;
                    $display("FAIL stable_hold: got %h expected %h", out_data, hold_data);
                end
            end
            hold_valid = out_valid && !out_ready;
            hold_data  = out_data;
            if (dut.w_push && !dut.w_pop && dut.r_count == DEPTH) begin
                total++;
                bad++;
                $display("FAIL fifo_overflow: push with occupancy %0d", dut.r_count);
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_word: got %h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        bad++;
                        $display("FAIL word: got %h expected %h", out_data, e);
                    end
`ifdef ACT_PACKER_PARITY_EN
                    total++;
                    if (out_parity !== ^e) begin
                        bad++;
                        $display("FAIL parity: got %b expected %b for %h", out_parity, ^e, e);
                    end
`endif
                end
            end
        end else begin
            hold_valid = 1'b0;
        end
    end

    initial begin
        int n;
        bit popped;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check("rst_pop_out", int'(pop_out), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy_out), 0);
        check("rst_done", int'(done_out), 0);
        check("rst_out_data", int'(out_data), 0);

        // Counting pattern: words 0123, 4567, 89AB, CDEF repeating.
        ready_mode = 0;
        run_row("pattern", 1'b1);
        wait_empty("pattern");

        // Consumer stalled for the whole row: FIFO fills, extra start ignored.
        ready_mode = 1;
        out_ready  = 1'b0;
        run_row("stall", 1'b0);
        check("stall_occupancy", int'(dut.r_count), DEPTH);
        check("stall_valid", int'(out_valid), 1);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        popped = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (pop_out || busy_out) popped = 1'b1;
        end
        check("stall_start_ignored", int'(popped), 0);
        check("stall_queue_len", exp_q.size(), DEPTH);
        ready_mode = 0;
        wait_empty("stall");

        // Reset in the middle of a row.
        pattern_mode = 1'b0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        n = 0;
        while (ch_idx < 31 && n < 100) begin
            tick();
            n++;
        end
        check("abort_reach_cycle30", int'(n >= 100), 0);
        rst_in = 1'b1;
        exp_q.delete();
        tick();
        rst_in = 1'b0;
        check("abort_pop_out", int'(pop_out), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy_out), 0);
        run_row("after_abort", 1'b0);
        wait_empty("after_abort");

        // Toggling consumer during POP: simultaneous push and pop.
        ready_mode = 2;
        out_ready  = 1'b0;
        run_row("toggle", 1'b1);
        wait_empty("toggle");

        // Random rows with a random consumer.
        ready_mode = 3;
        for (int r = 0; r < 3; r++) begin
            run_row("random", 1'b0);
        end
        ready_mode = 0;
        wait_empty("random");

        repeat (3) tick();
        check("final_queue_empty", exp_q.size(), 0);
        check("final_out_valid", int'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
